// File: rtl/trig_capture.sv
// Ring-buffer pre/post-trigger capture of 14-bit ADC samples, streamed out as 16-bit words.
// Latency: first word 2 cycles after readout starts, then one word per 2 cycles; dout holds while stalled.
// Optional TRIG_TIMESTAMP_EN prepends a two-word trigger timestamp header to each event.
module trig_capture #(
    parameter int AW   = 6,
    parameter int PRE  = 8,
    parameter int POST = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] adat,
    input  logic        tsig,
    input  logic        arm,
    output logic        busy,
    output logic [15:0] dout,
    output logic        dvalid,
    input  logic        dready,
    output logic        dlast,
    output logic        trg_lost
);
    localparam int DEPTH = 2**AW;
`ifdef TRIG_TIMESTAMP_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int NWORDS = PRE + POST + HDR;
    localparam int CW     = AW + 2;

    generate
        if (PRE < 1 || PRE > DEPTH - 1 || POST < 1 || PRE + POST > DEPTH) begin : g_param_check
            $error("trig_capture: PRE/POST do not fit the ring buffer");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READ} state_t;

    state_t        state;
    logic [13:0]   mem [DEPTH];
    logic [13:0]   ram_q;
    logic [AW-1:0] wp;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] post_cnt;
    logic [CW-1:0] issued;
    logic          fetched;
    logic          wr_en;
    logic          rd_en;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0]   ts;
    logic [31:0]   ts_lat;
`endif

    assign wr_en = (state == S_FILL) || (state == S_ARMED) || (state == S_POST);
    // One word in flight: fetch only when the output register is empty or draining this cycle.
    assign rd_en = (state == S_READ) && !fetched && (!dvalid || dready) && (issued != CW'(NWORDS));

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wp] <= adat;
        if (rd_en)
            ram_q <= mem[rd_addr];
    end

`ifdef TRIG_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ts <= '0;
        else
            ts <= ts + 32'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wp       <= '0;
            rd_addr  <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            issued   <= '0;
            fetched  <= 1'b0;
            busy     <= 1'b0;
            dout     <= '0;
            dvalid   <= 1'b0;
            dlast    <= 1'b0;
            trg_lost <= 1'b0;
`ifdef TRIG_TIMESTAMP_EN
            ts_lat   <= '0;
`endif
        end else begin
            trg_lost <= tsig && (state != S_ARMED);
            if (wr_en)
                wp <= wp + AW'(1);
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state    <= S_FILL;
                        fill_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (fill_cnt == CW'(PRE - 1))
                        state <= S_ARMED;
                    fill_cnt <= fill_cnt + CW'(1);
                end
                S_ARMED: begin
                    if (tsig) begin
                        // The sample written this cycle sits at wp; the window starts PRE earlier.
                        rd_addr  <= wp - AW'(PRE);
                        post_cnt <= CW'(1);
                        issued   <= '0;
                        fetched  <= 1'b0;
                        state    <= (POST == 1) ? S_READ : S_POST;
`ifdef TRIG_TIMESTAMP_EN
                        ts_lat   <= ts;
`endif
                    end
                end
                S_POST: begin
                    if (post_cnt == CW'(POST - 1))
                        state <= S_READ;
                    post_cnt <= post_cnt + CW'(1);
                end
                S_READ: begin
                    fetched <= rd_en;
                    if (rd_en) begin
                        issued <= issued + CW'(1);
`ifdef TRIG_TIMESTAMP_EN
                        if (issued >= CW'(HDR))
                            rd_addr <= rd_addr + AW'(1);
`else
                        rd_addr <= rd_addr + AW'(1);
`endif
                    end
                    if (fetched) begin
`ifdef TRIG_TIMESTAMP_EN
                        if (issued == CW'(1))
                            dout <= ts_lat[31:16];
                        else if (issued == CW'(2))
                            dout <= ts_lat[15:0];
                        else
                            dout <= {2'b00, ram_q};
`else
                        dout <= {2'b00, ram_q};
`endif
                        dvalid <= 1'b1;
                        dlast  <= (issued == CW'(NWORDS));
                    end else if (dvalid && dready) begin
                        dvalid <= 1'b0;
                        dlast  <= 1'b0;
                        if (dlast) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
